// File: rtl/wb_word_adapter.sv
// wb_word_adapter
// Bridges 16-bit Wishbone classic word requests onto an 8-bit Wishbone
// byte port feeding the SPI SRAM controller. Each word is split into two
// big-endian byte cycles: the even byte carries bits 15:8 and the odd byte
// carries bits 7:0. A one-cycle strobe-low gap sits between the two byte
// cycles so the controller can re-arm its chip select.
//
// Optional feature: define WB_WORD_ADAPTER_CACHE_EN to add a one-entry,
// write-through, write-allocate word cache that answers repeated reads of
// the same word without touching the downstream port.

module wb_word_adapter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic [23:0] adr_i,
    input  logic        we_i,
    input  logic [15:0] dat_i,
    output logic        ack_o,
    output logic [15:0] dat_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [23:0] wbm_adr_o,
    output logic        wbm_we_o,
    output logic [7:0]  wbm_dat_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic [7:0]  wbm_dat_i
);

    typedef enum logic [2:0] {
        IDLE,
        BYTE0,
        GAP,
        BYTE1,
        ACK
    } state_t;

    state_t      state;
    logic [22:0] adr_q;
    logic        we_q;
    logic [15:0] dat_q;
    logic        req;
    logic        hit;
    logic        unused_adr0;

    // The downstream port only ever issues classic single cycles.
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;

    // The upstream port is word-addressed, so the byte-select bit is dropped.
    assign unused_adr0 = adr_i[0];

    assign req = cyc_i & stb_i;

`ifdef WB_WORD_ADAPTER_CACHE_EN
    logic        cache_valid;
    logic [22:0] cache_tag;
    logic [15:0] cache_data;

    // Only reads are answered from the cache; writes always go downstream.
    assign hit = cache_valid && (cache_tag == adr_i[23:1]) && !we_i;
`else
    assign hit = 1'b0;
`endif

    // Transfer sequencer: accepts a word, walks the two byte cycles with the
    // strobe gap between them, and drives every output from a register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            adr_q     <= '0;
            we_q      <= 1'b0;
            dat_q     <= '0;
            ack_o     <= 1'b0;
            dat_o     <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_adr_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_dat_o <= '0;
`ifdef WB_WORD_ADAPTER_CACHE_EN
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack_o <= 1'b0;
                    if (req && !ack_o) begin
                        adr_q <= adr_i[23:1];
                        we_q  <= we_i;
                        dat_q <= dat_i;
`ifdef WB_WORD_ADAPTER_CACHE_EN
                        if (hit) begin
                            ack_o <= 1'b1;
                            dat_o <= cache_data;
                            state <= ACK;
                        end else begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_adr_o <= {adr_i[23:1], 1'b0};
                            wbm_we_o  <= we_i;
                            wbm_dat_o <= dat_i[15:8];
                            state     <= BYTE0;
                        end
`else
                        if (!hit) begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_adr_o <= {adr_i[23:1], 1'b0};
                            wbm_we_o  <= we_i;
                            wbm_dat_o <= dat_i[15:8];
                            state     <= BYTE0;
                        end
`endif
                    end
                end
                BYTE0: begin
                    if (!req) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= IDLE;
                    end else if (wbm_ack_i) begin
                        if (!we_q) begin
                            dat_o[15:8] <= wbm_dat_i;
                        end
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (!req) begin
                        state <= IDLE;
                    end else begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_adr_o <= {adr_q, 1'b1};
                        wbm_dat_o <= dat_q[7:0];
                        state     <= BYTE1;
                    end
                end
                BYTE1: begin
                    if (!req) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= IDLE;
                    end else if (wbm_ack_i) begin
                        if (!we_q) begin
                            dat_o[7:0] <= wbm_dat_i;
                        end
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        ack_o     <= 1'b1;
                        state     <= ACK;
`ifdef WB_WORD_ADAPTER_CACHE_EN
                        cache_valid <= 1'b1;
                        cache_tag   <= adr_q;
                        cache_data  <= we_q ? dat_q : {dat_o[15:8], wbm_dat_i};
`endif
                    end
                end
                ACK: begin
                    ack_o <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
